// File: rtl/serial_seq_tx.sv
// ----------------------------------------------------------------------------
// serial_seq_tx
//
// Serial bit-stream transmitter feeding the single-bit `x` input of the
// sequence-detector FSMs. A parallel pattern word plus a bit count is taken
// over a load/ready handshake and shifted out MSB-first (bit len-1 first),
// one bit per clock. Words can follow each other with no idle gap: the
// transmitter is ready again while the last bit of a word is on the line.
//
// Parameters:
//   WIDTH    - maximum pattern length in bits (data word width)
//   LEN_W    - width of `len`; 2**LEN_W must exceed WIDTH
//   IDLE_BIT - value driven on `x` while no word is active
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-low reset (0 = reset at an edge)
//   load    in   request to transmit data/len
//   data    in   pattern word, bit len-1 is sent first
//   len     in   number of bits to send, legal range 1..WIDTH
//   ready   out  a word can be accepted at the coming edge
//   x       out  serial bit, registered
//   x_valid out  x carries a pattern bit this cycle
//   done    out  high while the last bit of a word is on x
//   err     out  one-cycle pulse after a word was rejected for illegal len
// ----------------------------------------------------------------------------

module serial_seq_tx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LEN_W    = 4,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic             err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    // State
    logic [0:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;    // bits remaining, including the one on x
    logic [WIDTH-1:0] sreg_q,  sreg_d;   // word left-aligned: bit on x sits at the MSB
    logic             x_q,     x_d;
    logic             err_q,   err_d;

    // Handshake decode
    logic             last;
    logic             len_ok;
    logic             accept;
    logic             reject;
    logic [LEN_W-1:0] shamt;
    logic [WIDTH-1:0] aligned;

    always_comb begin
        last   = (state_q == SHIFT) && (cnt_q == CNT_ONE);
        ready  = (state_q == IDLE) || last;
        len_ok = (len != '0) && (len <= LEN_MAX);
        accept = load && ready && len_ok;
        reject = load && ready && !len_ok;
        // Move bit len-1 up to the MSB so that every word shifts out from the
        // same position regardless of its length; bits above len-1 fall off.
        shamt   = LEN_MAX - len;
        aligned = data << shamt;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        x_d     = x_q;
        err_d   = reject;

        if (accept) begin
            // Also covers the back-to-back reload on the last bit of a word.
            state_d = SHIFT;
            cnt_d   = len;
            sreg_d  = aligned;
            x_d     = aligned[WIDTH-1];
        end else if (state_q == SHIFT) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                sreg_d  = '0;
                x_d     = IDLE_BIT;
            end else begin
                cnt_d  = cnt_q - CNT_ONE;
                sreg_d = sreg_q << 1;
                x_d    = sreg_d[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            x_q     <= IDLE_BIT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            x_q     <= x_d;
            err_q   <= err_d;
        end
    end

    // Outputs
    always_comb begin
        x       = x_q;
        x_valid = (state_q == SHIFT);
        done    = last;
        err     = err_q;
    end

endmodule

// File: tb/tb_serial_seq_tx.sv
// ----------------------------------------------------------------------------
// tb_serial_seq_tx
//
// Directed table of per-cycle records: the inputs applied at one rising edge
// and the outputs expected just after that edge. Followed by a hand-written
// sequence that waits (bounded) for the end of a word and checks the bits
// collected on x.
// ----------------------------------------------------------------------------

module tb_serial_seq_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             done;
    logic             err;

    serial_seq_tx #(
        .WIDTH    (WIDTH),
        .LEN_W    (LEN_W),
        .IDLE_BIT (1'b0)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .data    (data),
        .len     (len),
        .ready   (ready),
        .x       (x),
        .x_valid (x_valid),
        .done    (done),
        .err     (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             rst;
        logic             ld;
        logic [WIDTH-1:0] d;
        logic [LEN_W-1:0] l;
        logic             ex;
        logic             ev;
        logic             edn;
        logic             eer;
        logic             erdy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic ld, input logic [WIDTH-1:0] d,
                       input logic [LEN_W-1:0] l, input logic ex, input logic ev,
                       input logic edn, input logic eer, input logic erdy);
        vec_t v;
        v.rst = rst; v.ld = ld; v.d = d; v.l = l;
        v.ex = ex; v.ev = ev; v.edn = edn; v.eer = eer; v.erdy = erdy;
        vecs.push_back(v);
    endtask

    // Idle cycle with no load; only the expected outputs vary.
    task automatic idl(input logic ex, input logic ev, input logic edn, input logic eer,
                       input logic erdy);
        add(1'b1, 1'b0, 8'h00, 4'd0, ex, ev, edn, eer, erdy);
    endtask

    task automatic chk(input string name, input int idx, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %b want %b", idx, name, got, want);
        end
    endtask

    initial begin
        logic [5:0] bits;
        int         nbits;
        bit         seen_done;

        reset = 1'b0;
        load  = 1'b0;
        data  = '0;
        len   = '0;

        //   rst  ld    data   len    x  v  dn er rdy
        // 1: reset then a full 8-bit word
        add(1'b0, 1'b0, 8'h00, 4'd0,  0, 0, 0, 0, 1);
        add(1'b0, 1'b0, 8'h00, 4'd0,  0, 0, 0, 0, 1);
        add(1'b1, 1'b1, 8'h99, 4'd8,  1, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(1, 1, 1, 0, 1);
        idl(0, 0, 0, 0, 1);
        // 2: back-to-back 3-bit then 4-bit, load held while busy
        add(1'b1, 1'b1, 8'h05, 4'd3,  1, 1, 0, 0, 0);
        add(1'b1, 1'b1, 8'h02, 4'd4,  0, 1, 0, 0, 0);
        add(1'b1, 1'b1, 8'h02, 4'd4,  1, 1, 1, 0, 1);
        add(1'b1, 1'b1, 8'h02, 4'd4,  0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        idl(0, 1, 1, 0, 1);
        idl(0, 0, 0, 0, 1);
        // 3: single-bit word, then a 5-bit partial word directly after it
        add(1'b1, 1'b1, 8'hFF, 4'd1,  1, 1, 1, 0, 1);
        add(1'b1, 1'b1, 8'hE6, 4'd5,  0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        idl(0, 1, 1, 0, 1);
        idl(0, 0, 0, 0, 1);
        // 4: illegal lengths while idle, then on the last bit of a word
        add(1'b1, 1'b1, 8'hFF, 4'd0,  0, 0, 0, 1, 1);
        idl(0, 0, 0, 0, 1);
        add(1'b1, 1'b1, 8'hFF, 4'd9,  0, 0, 0, 1, 1);
        idl(0, 0, 0, 0, 1);
        add(1'b1, 1'b1, 8'h02, 4'd2,  1, 1, 0, 0, 0);
        add(1'b1, 1'b1, 8'hFF, 4'd0,  0, 1, 1, 0, 1);
        add(1'b1, 1'b1, 8'hFF, 4'd0,  0, 0, 0, 1, 1);
        idl(0, 0, 0, 0, 1);
        // 5: reset after three bits (load asserted during reset is ignored)
        add(1'b1, 1'b1, 8'hA5, 4'd8,  1, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        add(1'b0, 1'b1, 8'hFF, 4'd8,  0, 0, 0, 0, 1);
        add(1'b1, 1'b1, 8'h03, 4'd2,  1, 1, 0, 0, 0);
        idl(1, 1, 1, 0, 1);
        idl(0, 0, 0, 0, 1);
        // 6: busy load dropped early is lost; held load goes out after the word
        add(1'b1, 1'b1, 8'hC3, 4'd8,  1, 1, 0, 0, 0);
        add(1'b1, 1'b1, 8'h0F, 4'd8,  1, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        add(1'b1, 1'b1, 8'h0F, 4'd8,  1, 1, 1, 0, 1);
        add(1'b1, 1'b1, 8'h0F, 4'd8,  0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(0, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        idl(1, 1, 0, 0, 0);
        idl(1, 1, 1, 0, 1);
        idl(0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset = vecs[i].rst;
            load  = vecs[i].ld;
            data  = vecs[i].d;
            len   = vecs[i].l;
            @(posedge clock);
            #1;
            chk("x",       i, x,       vecs[i].ex);
            chk("x_valid", i, x_valid, vecs[i].ev);
            chk("done",    i, done,    vecs[i].edn);
            chk("err",     i, err,     vecs[i].eer);
            chk("ready",   i, ready,   vecs[i].erdy);
        end

        // Hand sequence: 6-bit word 101010, collect bits until done (bounded).
        @(negedge clock);
        load = 1'b1;
        data = 8'h2A;
        len  = 4'd6;
        @(negedge clock);
        load = 1'b0;
        data = 8'hFF;  // must not affect the word in flight
        bits      = '0;
        nbits     = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (x_valid) begin
                bits = {bits[4:0], x};
                nbits++;
            end
            if (done) seen_done = 1'b1;
            if (!seen_done) @(negedge clock);
        end
        n_vec++;
        if (!seen_done) begin
            n_bad++;
            $display("FAIL seq done: got no done within 20 cycles, want done");
        end
        n_vec++;
        if (nbits != 6) begin
            n_bad++;
            $display("FAIL seq bitcount: got %0d want 6", nbits);
        end
        n_vec++;
        if (bits !== 6'b101010) begin
            n_bad++;
            $display("FAIL seq bits: got %b want 101010", bits);
        end
        @(negedge clock);
        n_vec++;
        if (x_valid !== 1'b0 || x !== 1'b0) begin
            n_bad++;
            $display("FAIL seq idle: got x_valid %b x %b want 0 0", x_valid, x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_seq_tx.md
Name: serial_seq_tx

Overview:
- Serial bit-stream transmitter: the sending end of the single-bit `x` interface consumed by the sequence-detector FSMs.
- Accepts a parallel pattern word plus a bit count over a valid/ready handshake, then drives it MSB-first onto `x`, one bit per clock.
- Replaces hand-written per-bit stimulus and feeds detector blocks in-system.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, maximum pattern length in bits; data word width.
- LEN_W, 4, width of `len` input; must satisfy 2^LEN_W > WIDTH.
- IDLE_BIT, 0, value driven on `x` when no pattern is active.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset: sampled on the rising edge of clock; 0 = reset.
- load, input, 1, request to transmit `data`/`len`.
- data, input, WIDTH, pattern word; bit `len-1` is sent first.
- len, input, LEN_W, number of bits to send, 1..WIDTH.
- ready, output, 1, transmitter can accept a word this cycle.
- x, output, 1, serial bit out; registered.
- x_valid, output, 1, `x` carries a pattern bit this cycle.
- done, output, 1, one-cycle pulse coincident with the last bit of a word.
- err, output, 1, one-cycle pulse: a word was rejected for illegal `len`.

Behaviour:
- Reset (`reset` == 0 at an edge):
  - state = IDLE; shift register and bit counter cleared.
  - Outputs: `x` = IDLE_BIT, `x_valid` = 0, `done` = 0, `err` = 0, `ready` = 1.
  - Reset mid-word abandons the word immediately; no `done` pulse.
- States:
  - IDLE: no active word.
  - SHIFT: counter `cnt` holds the remaining bits including the current one.
- `ready` (combinational): 1 in IDLE; in SHIFT, 1 only when `cnt` == 1 (last bit on the line).
- Accept: at an edge where `load` && `ready` && 1 <= `len` <= WIDTH.
  - Register `data`, set `cnt` = `len`, enter SHIFT.
  - `x` = `data[len-1]`, `x_valid` = 1 from that edge.
  - Latency: first bit appears 1 clock after `load` is sampled.
- Shift: each edge in SHIFT with `cnt` > 1 → `cnt`--, and `x` takes the next lower bit.
  - Bits `len-1` down to 0 are sent over exactly `len` consecutive cycles.
- Last bit (`cnt` == 1): `done` = 1 for that cycle. At the next edge:
  - If a new word is accepted: reload per Accept; the new word's first bit directly follows, no gap, and `x_valid` stays 1.
  - Otherwise: go to IDLE with `x` = IDLE_BIT and `x_valid` = 0.
- Illegal length (`load` && `ready` && (`len` == 0 or `len` > WIDTH)):
  - Word is rejected; `err` = 1 for one cycle.
  - State is unchanged. If this happens on the last bit, the transmitter proceeds to IDLE.
- `load` while `ready` == 0: ignored, no `err`. The requester must hold `load` until `ready` is seen.
- `len` == 1: a single-cycle word. `done` and `x_valid` both high on the same cycle; `ready` = 1 during it.
- Bits of `data` above `len-1` are don't-care and never appear on `x`.
- `data`/`len` are sampled only at the accept edge; later changes have no effect on the word in flight.

Test Plan:
1. Reset then single word: hold `reset` = 0 for 2 cycles; check `x` = 0, `x_valid` = 0, `ready` = 1. Then `load` with `data` = 8'b1001_1001, `len` = 8 → over the next 8 cycles `x` = 1,0,0,1,1,0,0,1, `x_valid` = 1. `done` high on the 8th bit; `x_valid` = 0 and `x` = 0 one cycle later.
2. Back-to-back: `len` = 3, `data` = 3'b101, then `load` held with `len` = 4, `data` = 4'b0010 → `ready` rises only on the 3rd bit. `x` = 1,0,1,0,0,1,0 with no gap; `x_valid` continuous for 7 cycles; `done` pulses on cycles 3 and 7.
3. Short and partial words: `len` = 1, `data` = 8'hFF → one cycle with `x` = 1, `done` = 1, `x_valid` = 1. Then `len` = 5, `data` = 8'b1110_0110 → `x` = 0,0,1,1,0; upper bits are not sent.
4. Illegal length: `load` with `len` = 0, and separately with `len` = 9 (WIDTH = 8) → `err` pulses 1 cycle each time; `x_valid` stays 0, `ready` stays 1, `x` = IDLE_BIT.
5. Reset mid-word: start `data` = 8'hA5, `len` = 8; assert `reset` = 0 after 3 bits (1,0,1) → at the next edge `x` = 0, `x_valid` = 0, no `done`, `ready` = 1. A new word is accepted normally after release.
6. Busy-ignore: assert `load` with `data` = 8'h0F while bit 2 of an 8-bit word is on the line → the word in flight is uncorrupted, `err` = 0, and the second word is sent only if `load` is still held when `ready` = 1.
